elbeth_dmem_responder: RTL
==========================

// Module: elbeth_dmem_responder
// PURPOSE
//  Memory-side responder for the EXS-stage data-memory interface: accepts en/size/sign/addr/wdata from the core,
//  performs byte/half/word access on an internal RAM after a fixed latency, returns ready (+ rdata / fault flags).
//  Closes the en & ~ready stall loop the control unit uses to freeze IF/ID; flags feed the exception path.
// PARAMETERS
//  LATENCY      2     cycles from first sampled en to ready (>=1); fault responses ignore it
//  DEPTH_WORDS  1024  32-bit words in RAM; byte-address range 0 .. 4*DEPTH_WORDS-1
// PORTS
//  clk              in   1   clock, all logic on rising edge
//  rst              in   1   synchronous, active-high reset
//  dmem_en          in   1   request valid; held with all attributes stable until dmem_ready
//  dmem_wr          in   1   1 = store, 0 = load
//  dmem_size        in   2   0 byte, 1 half, 2 word (3 reserved -> access fault)
//  dmem_sign        in   1   1 = sign-extend load, 0 = zero-extend
//  dmem_addr        in   32  byte address
//  dmem_wdata       in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  dmem_rdata       out  32  load result, extended; valid only while dmem_ready
//  dmem_ready       out  1   one-cycle response pulse
//  dmem_misaligned  out  1   with ready: half addr[0]!=0 or word addr[1:0]!=0
//  dmem_fault       out  1   with ready: addr out of range or size==3
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, dmem_ready=0, dmem_misaligned=0, dmem_fault=0, dmem_rdata=0. RAM not cleared.
//  - FSM IDLE -> WAIT -> RESP; cycle 0 = first cycle en seen high in IDLE.
//  - IDLE: en=1 & (misaligned|fault) -> RESP with flag set, no RAM access (ready in cycle 1).
//          en=1 & clean & LATENCY==1 -> RESP (ready in cycle 1); LATENCY>1 -> WAIT, cnt=1.
//  - WAIT: cnt increments; at cnt==LATENCY-1 -> RESP, so ready is high in cycle LATENCY. Attributes re-sampled not needed.
//          en drops in WAIT -> abort to IDLE, no write, no ready.
//  - RESP: ready=1 exactly one cycle; store commits on the edge entering RESP (byte-enables from size/addr[1:0]),
//          load data registered on that same edge. Flags valid only in RESP.
//  - RESP -> IDLE; en sampled in RESP cycle is the old request (core advances on that edge): ignore it.
//    Next request starts in the following cycle: back-to-back throughput = one access per LATENCY+1 cycles.
//  - Byte lanes little-endian: byte lane addr[1:0]; half lane addr[1]. Store writes only enabled lanes.
//  - Load extension: byte -> bit 7 if sign else 0 into [31:8]; half -> bit 15 into [31:16]; word unchanged.
//  - Fault priority: fault over misaligned (never both set); faulting access touches no RAM.
//  - RAM index = addr[31:2]; range check on full 32-bit addr, no wrap-around.
//  - rst mid-WAIT: IDLE next cycle, no write, no ready; rst in RESP cycle: write already committed stands.
//  - dmem_rdata held at last value outside RESP; flags cleared outside RESP.
// STRUCTURE
//  - elbeth_definitions.v: MEM_SIZE_B/H/W constants (2'd0/1/2), responder state encodings.
//  - Sub-module elbeth_dmem_ram: single-port, synchronous, 4 byte-write-enable RAM (DEPTH_WORDS x 32).
//  - Top: FSM + latency counter, alignment/range check, lane-enable and wdata replication, load extract/extend.
// TESTING
//  1. SW 0xDEADBEEF @0x100, LW @0x100 (LATENCY=2) -> ready in cycle 2 each, rdata=0xDEADBEEF, flags 0.
//  2. SB 0xAB @0x103 then LB @0x103 -> 0xFFFFFFAB; LBU -> 0x000000AB; LW @0x100 -> 0xABADBEEF.
//  3. SH 0x8001 @0x102, LH -> 0xFFFF8001, LHU -> 0x00008001; LW @0x100 -> 0x8001BEEF.
//  4. LH @0x101 -> ready cycle 1, misaligned=1, fault=0; SW @0x102 -> misaligned=1, RAM @0x100 unchanged.
//  5. LW @4*DEPTH_WORDS, size=3 @0x0 -> ready cycle 1, fault=1, misaligned=0.
//  6. SW @0x200 with en dropped in WAIT, and separately rst in WAIT -> no ready, later LW @0x200 returns old data.

Source files
------------

// File: rtl/elbeth_dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// elbeth_dmem_responder_pkg
//   Shared definitions for the EXS-stage data-memory responder: access size
//   encodings, responder FSM state encodings, and small combinational helpers
//   for access checking, byte-lane enables, store-data replication and load
//   extraction/extension.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package elbeth_dmem_responder_pkg;

  // Access size encodings driven by the core on dmem_size.
  localparam logic [1:0] MEM_SIZE_B   = 2'd0;
  localparam logic [1:0] MEM_SIZE_H   = 2'd1;
  localparam logic [1:0] MEM_SIZE_W   = 2'd2;
  localparam logic [1:0] MEM_SIZE_RSV = 2'd3;

  // Responder FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic fault;
    logic misaligned;
  } access_check_t;

  // Fault wins over misaligned, so at most one flag is ever set. The range
  // check uses the whole word index, so high address bits never alias.
  function automatic access_check_t checkAccess(input logic [1:0]  size,
                                                input logic [31:0] addr,
                                                input logic [29:0] wordLimit);
    access_check_t res;
    res.fault      = (size == MEM_SIZE_RSV) || (addr[31:2] >= wordLimit);
    res.misaligned = !res.fault &&
                     (((size == MEM_SIZE_H) && addr[0]) ||
                      ((size == MEM_SIZE_W) && (addr[1:0] != 2'b00)));
    return res;
  endfunction

  // Little-endian byte-lane enables for a store.
  function automatic logic [3:0] laneEnables(input logic [1:0] size,
                                             input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_SIZE_B: be = 4'b0001 << lane;
      MEM_SIZE_H: be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_SIZE_W: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data copied onto every lane it could target, so the
  // byte enables alone select what lands in the RAM.
  function automatic logic [31:0] replicateWdata(input logic [1:0]  size,
                                                 input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      MEM_SIZE_B: rep = {4{wdata[7:0]}};
      MEM_SIZE_H: rep = {2{wdata[15:0]}};
      default:    rep = wdata;
    endcase
    return rep;
  endfunction

  // Pick the addressed byte/half out of a RAM word and extend it.
  function automatic logic [31:0] extractLoad(input logic [1:0]  size,
                                              input logic        sign,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] res;
    case (lane)
      2'd0:    byteVal = word[7:0];
      2'd1:    byteVal = word[15:8];
      2'd2:    byteVal = word[23:16];
      default: byteVal = word[31:24];
    endcase
    halfVal = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_SIZE_B: res = {{24{sign & byteVal[7]}}, byteVal};
      MEM_SIZE_H: res = {{16{sign & halfVal[15]}}, halfVal};
      default:    res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/elbeth_dmem_ram.sv
// ---------------------------------------------------------------------------
// elbeth_dmem_ram
//   Single-port synchronous RAM, DEPTH_WORDS x 32 bits, with one write enable
//   per byte lane. A read registers the addressed word on the access edge;
//   the read register is only updated by reads, never by writes. Contents
//   are not cleared by reset.
//   Ports:
//     clk_i    clock
//     en_i     access strobe for this cycle
//     we_i     1 = write enabled lanes, 0 = read
//     be_i     byte-lane write enables
//     addr_i   word index
//     wdata_i  write data (already lane-positioned)
//     rdata_o  registered read data
// ---------------------------------------------------------------------------
module elbeth_dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/elbeth_dmem_responder.sv
// ---------------------------------------------------------------------------
// elbeth_dmem_responder
//   Memory-side responder for the EXS-stage data-memory interface. Accepts a
//   held request from the core, performs a byte/half/word access on internal
//   RAM after a fixed latency and returns a one-cycle ready pulse with load
//   data and fault/misaligned flags. Faulting or misaligned requests answer
//   after one cycle without touching the RAM.
//   Ports:
//     clk              clock, rising edge
//     rst              synchronous active-high reset
//     dmem_en          request valid, held stable until dmem_ready
//     dmem_wr          1 = store, 0 = load
//     dmem_size        0 byte, 1 half, 2 word, 3 reserved (fault)
//     dmem_sign        1 = sign-extend load
//     dmem_addr        byte address
//     dmem_wdata       right-aligned store data
//     dmem_rdata       extended load result (valid with ready, held otherwise)
//     dmem_ready       one-cycle response pulse
//     dmem_misaligned  misaligned half/word access, with ready
//     dmem_fault       out-of-range address or reserved size, with ready
// ---------------------------------------------------------------------------
module elbeth_dmem_responder
  import elbeth_dmem_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_en,
  input  logic        dmem_wr,
  input  logic [1:0]  dmem_size,
  input  logic        dmem_sign,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_misaligned,
  output logic        dmem_fault
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LATENCY - 1);
  localparam logic [29:0]      WORD_LIMIT = 30'(DEPTH_WORDS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misaligned_q, fault_q;
  logic             loadResp_q;
  logic [1:0]       lane_q, size_q;
  logic             sign_q;
  logic [31:0]      rdataHold_q;

  access_check_t    chk;
  logic             accessClean;
  logic             enterResp;
  logic             ramAccess;
  logic [31:0]      ramRdata;
  logic [31:0]      loadData;

  assign chk         = checkAccess(dmem_size, dmem_addr, WORD_LIMIT);
  assign accessClean = !chk.fault && !chk.misaligned;

  // Next-state logic. Cycle 0 is the IDLE cycle in which en is first seen;
  // flagged requests skip WAIT entirely. Dropping en during WAIT abandons the
  // request. The en value seen in RESP still belongs to the finished request,
  // so RESP always returns to IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enterResp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_en) begin
          if (!accessClean || (LATENCY == 1)) begin
            state_d   = ST_RESP;
            enterResp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!dmem_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          enterResp = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The RAM is touched only on the edge entering RESP, so an abort or a reset
  // before that edge leaves memory untouched.
  assign ramAccess = enterResp && accessClean && !rst;

  elbeth_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (IDX_W)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (ramAccess),
    .we_i   (dmem_wr),
    .be_i   (laneEnables(dmem_size, dmem_addr[1:0])),
    .addr_i (dmem_addr[IDX_W+1:2]),
    .wdata_i(replicateWdata(dmem_size, dmem_wdata)),
    .rdata_o(ramRdata)
  );

  // Lane/size/sign are captured alongside the RAM read so the extraction in
  // RESP does not depend on the core still driving them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      loadResp_q   <= 1'b0;
      lane_q       <= 2'd0;
      size_q       <= MEM_SIZE_B;
      sign_q       <= 1'b0;
      rdataHold_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= enterResp && chk.misaligned;
      fault_q      <= enterResp && chk.fault;
      loadResp_q   <= enterResp && accessClean && !dmem_wr;
      if (enterResp) begin
        lane_q <= dmem_addr[1:0];
        size_q <= dmem_size;
        sign_q <= dmem_sign;
      end
      if (loadResp_q) begin
        rdataHold_q <= loadData;
      end
    end
  end

  assign loadData        = extractLoad(size_q, sign_q, lane_q, ramRdata);
  assign dmem_rdata      = loadResp_q ? loadData : rdataHold_q;
  assign dmem_ready      = (state_q == ST_RESP);
  assign dmem_misaligned = misaligned_q;
  assign dmem_fault      = fault_q;

endmodule
